// File: rtl/ex_div_pkg.sv
// Shared widths, FSM states and sign-fix helper for the EX-stage divide unit.
package ex_div_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CNT_W      = $clog2(XLEN);
  localparam int unsigned RD_W       = 5;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned OP_UNS_BIT = 0;
  localparam int unsigned OP_REM_BIT = 1;

  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Apply the RV32M sign rules to an unsigned magnitude quotient/remainder.
  function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] q,
                                               input logic [XLEN-1:0] r,
                                               input logic            neg_q,
                                               input logic            neg_r,
                                               input logic            sel_rem);
    if (sel_rem) return neg_r ? (XLEN'(0) - r) : r;
    return neg_q ? (XLEN'(0) - q) : q;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// EX-stage divide request/response bundle between the pipeline/ctrl and ex_div.
interface ex_div_if;
  import ex_div_pkg::*;

  logic                 start;
  logic [OP_W-1:0]      op;
  logic [XLEN-1:0]      dividend;
  logic [XLEN-1:0]      divisor;
  logic [RD_W-1:0]      rd_addr;
  logic                 flush;
  logic                 pause_req;
  logic                 unpause;
  logic [XLEN-1:0]      result;
  logic                 result_valid;
  logic [RD_W-1:0]      result_rd;

  modport master (
    output start, op, dividend, divisor, rd_addr, flush,
    input  pause_req, unpause, result, result_valid, result_rd
  );

  modport slave (
    input  start, op, dividend, divisor, rd_addr, flush,
    output pause_req, unpause, result, result_valid, result_rd
  );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with pipeline
// pause/unpause handshake and flush abandonment.
module ex_div
  import ex_div_pkg::*;
(
  input logic   clk,
  input logic   rst,
  ex_div_if.slave bus
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [XLEN-1:0]   quot, quot_n;
  logic [XLEN-1:0]   rem, rem_n;
  logic [XLEN-1:0]   dvs, dvs_n;
  logic [XLEN-1:0]   res, res_n;
  logic [RD_W-1:0]   rd, rd_n;
  logic              neg_q, neg_q_n;
  logic              neg_r, neg_r_n;
  logic              is_rem, is_rem_n;

  logic              accept;
  logic              sgn, sa, sb;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   q_step, r_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      quot   <= '0;
      rem    <= '0;
      dvs    <= '0;
      res    <= '0;
      rd     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      quot   <= quot_n;
      rem    <= rem_n;
      dvs    <= dvs_n;
      res    <= res_n;
      rd     <= rd_n;
      neg_q  <= neg_q_n;
      neg_r  <= neg_r_n;
      is_rem <= is_rem_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    quot_n   = quot;
    rem_n    = rem;
    dvs_n    = dvs;
    res_n    = res;
    rd_n     = rd;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    is_rem_n = is_rem;

    accept = (state == IDLE) & bus.start & ~bus.flush;
    sgn    = ~bus.op[OP_UNS_BIT];
    sa     = sgn & bus.dividend[XLEN-1];
    sb     = sgn & bus.divisor[XLEN-1];

    // quot doubles as the dividend shift register; its MSB feeds the remainder.
    trial  = {rem, quot[XLEN-1]} - {1'b0, dvs};
    q_step = {quot[XLEN-2:0], ~trial[XLEN]};
    r_step = trial[XLEN] ? {rem[XLEN-2:0], quot[XLEN-1]} : trial[XLEN-1:0];

    unique case (state)
      IDLE: begin
        if (accept) begin
          rd_n     = bus.rd_addr;
          is_rem_n = bus.op[OP_REM_BIT];
          neg_q_n  = sa ^ sb;
          neg_r_n  = sa;
          quot_n   = sa ? (XLEN'(0) - bus.dividend) : bus.dividend;
          dvs_n    = sb ? (XLEN'(0) - bus.divisor) : bus.divisor;
          rem_n    = '0;
          cnt_n    = '0;
          if (bus.divisor == '0) begin
            res_n   = bus.op[OP_REM_BIT] ? bus.dividend : '1;
            state_n = DONE;
          end else if (sgn && bus.dividend == XLEN_MIN && bus.divisor == '1) begin
            res_n   = bus.op[OP_REM_BIT] ? '0 : XLEN_MIN;
            state_n = DONE;
          end else begin
            state_n = CALC;
          end
        end
      end
      CALC: begin
        quot_n = q_step;
        rem_n  = r_step;
        cnt_n  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(XLEN-1)) begin
          res_n   = sign_fix(q_step, r_step, neg_q, neg_r, is_rem);
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (bus.flush) state_n = IDLE;
  end

  // flush is already a registered command from ctrl; it only masks the DONE pulse.
  assign bus.pause_req    = accept | (state == CALC);
  assign bus.result_valid = (state == DONE) & ~bus.flush;
  assign bus.unpause      = (state == DONE) & ~bus.flush;
  assign bus.result       = res;
  assign bus.result_rd    = rd;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: scoreboard of expected results plus timing checks.
module tb_ex_div;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];

  ex_div_if bus ();

  ex_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'd0: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'($signed(a) / $signed(b));
      end
      2'd1: r = a / b;
      2'd2: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'($signed(a) % $signed(b));
      end
      default: r = a % b;
    endcase
    return r;
  endfunction

  // Output monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (bus.result_valid || bus.unpause)) begin
      checks++;
      if (bus.result_valid !== bus.unpause) begin
        errors++;
        $display("FAIL pulse_pair: result_valid=%b unpause=%b", bus.result_valid, bus.unpause);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_result: got result=%h rd=%0d, expected no result",
                 bus.result, bus.result_rd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.result !== e.res || bus.result_rd !== e.rd) begin
          errors++;
          $display("FAIL result: got %h rd=%0d, expected %h rd=%0d",
                   bus.result, bus.result_rd, e.res, e.rd);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, input logic [31:0] exp_res,
                       output logic acc_pause);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.rd_addr  = rd;
    if (push) sb.push_back('{res: exp_res, rd: rd});
    @(negedge clk);
    acc_pause = bus.pause_req;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.op       = 2'($urandom);
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    bus.rd_addr  = 5'($urandom);
  endtask

  // Called in cycle 1; returns the cycle index of the result and the pause profile.
  task automatic wait_valid(output int lat, output int pauses, output logic done_pause);
    lat        = 1;
    pauses     = 0;
    done_pause = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        done_pause = bus.pause_req;
        break;
      end
      pauses += int'(bus.pause_req);
      @(posedge clk);
      #1;
      lat++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.op       = 2'd0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.rd_addr  = '0;
    idle_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.pause_req, bus.unpause, bus.result_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got pause/unpause/valid=%b%b%b, expected 000",
               bus.pause_req, bus.unpause, bus.result_valid);
    end
    checks++;
    if (bus.result !== 32'd0 || bus.result_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: got result=%h rd=%0d, expected 0 0", bus.result, bus.result_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu_basic();
    logic acc;
    int   lat, pz;
    logic dp;
    issue(2'd1, 32'd100, 32'd7, 5'd3, 1'b1, 32'd14, acc);
    wait_valid(lat, pz, dp);
    checks++;
    if (lat != 33 || pz != 32 || acc !== 1'b1 || dp !== 1'b0) begin
      errors++;
      $display("FAIL divu_timing: got lat=%0d pauses=%0d acc=%b done_pause=%b, expected 33 32 1 0",
               lat, pz, acc, dp);
    end
    issue(2'd3, 32'd100, 32'd7, 5'd4, 1'b1, 32'd2, acc);
    wait_valid(lat, pz, dp);
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL remu_latency: got %0d, expected 33", lat);
    end
  endtask

  task automatic test_signed();
    logic acc;
    int   lat, pz;
    logic dp;
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 32'hFFFF_FFFD, acc);
    wait_valid(lat, pz, dp);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, 32'hFFFF_FFFF, acc);
    wait_valid(lat, pz, dp);
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 5'd7, 1'b1, 32'd1, acc);
    wait_valid(lat, pz, dp);
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL signed_latency: got %0d, expected 33", lat);
    end
  endtask

  task automatic test_special();
    logic acc;
    int   lat, pz;
    logic dp;
    issue(2'd1, 32'd5, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFFF, acc);
    wait_valid(lat, pz, dp);
    checks++;
    if (lat != 1 || pz != 0 || acc !== 1'b1 || dp !== 1'b0) begin
      errors++;
      $display("FAIL divzero_timing: got lat=%0d pauses=%0d acc=%b done_pause=%b, expected 1 0 1 0",
               lat, pz, acc, dp);
    end
    issue(2'd2, 32'd5, 32'd0, 5'd9, 1'b1, 32'd5, acc);
    wait_valid(lat, pz, dp);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL remzero_latency: got %0d, expected 1", lat);
    end
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h8000_0000, acc);
    wait_valid(lat, pz, dp);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL overflow_latency: got %0d, expected 1", lat);
    end
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'd0, acc);
    wait_valid(lat, pz, dp);
  endtask

  task automatic test_flush();
    logic acc;
    int   lat, pz;
    logic dp;
    issue(2'd1, 32'd1000, 32'd3, 5'd12, 1'b0, 32'd0, acc);
    idle_cycles(9);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.pause_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_pause: got %b in cycle 11, expected 0", bus.pause_req);
    end
    @(posedge clk);
    #1;
    issue(2'd1, 32'd1000, 32'd3, 5'd13, 1'b1, 32'd333, acc);
    wait_valid(lat, pz, dp);
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL post_flush_latency: got %0d, expected 33 (cycle 45)", lat);
    end

    // flush landing on the DONE cycle of a special case
    issue(2'd1, 32'd5, 32'd0, 5'd14, 1'b0, 32'd0, acc);
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.unpause !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: got valid=%b unpause=%b, expected 0 0",
               bus.result_valid, bus.unpause);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;

    // start and flush together must not be accepted
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    bus.op       = 2'd1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd2;
    bus.rd_addr  = 5'd15;
    @(negedge clk);
    checks++;
    if (bus.pause_req !== 1'b0) begin
      errors++;
      $display("FAIL start_flush_pause: got %b, expected 0", bus.pause_req);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    idle_cycles(38);
  endtask

  task automatic test_reset_mid();
    logic acc;
    issue(2'd0, 32'd12345, 32'd17, 5'd16, 1'b0, 32'd0, acc);
    idle_cycles(4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.pause_req, bus.unpause, bus.result_valid} !== 3'b000 ||
        bus.result !== 32'd0 || bus.result_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid: got p/u/v=%b%b%b result=%h rd=%0d, expected all 0",
               bus.pause_req, bus.unpause, bus.result_valid, bus.result, bus.result_rd);
    end
    idle_cycles(38);
  endtask

  task automatic test_back_to_back();
    logic        acc;
    int          lat, pz;
    logic        dp;
    logic [1:0]  op;
    logic [31:0] a, b;
    int          exp_lat;
    issue(2'd1, 32'd81, 32'd9, 5'd17, 1'b1, 32'd9, acc);
    wait_valid(lat, pz, dp);
    issue(2'd3, 32'd82, 32'd9, 5'd18, 1'b1, 32'd1, acc);
    wait_valid(lat, pz, dp);
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL b2b_latency: got %0d, expected 33", lat);
    end
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = (i == 2) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 50)) : $urandom);
      if (i == 5) a = 32'h8000_0000;
      if (i == 6) b = 32'hFFFF_FFFF;
      exp_lat = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      issue(op, a, b, 5'(20 + i), 1'b1, ref_div(op, a, b), acc);
      wait_valid(lat, pz, dp);
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d, expected %0d", i, lat, exp_lat);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    idle_cycles(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
